// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and helpers for the pipelined stream multiplier
package mul_pkg;

  localparam int unsigned MAX_W      = 64;
  localparam int unsigned DEF_N      = 32;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_TAG_W  = 4;

  function automatic int unsigned rows_per_stage(input int unsigned n, input int unsigned stages);
    return n / stages;
  endfunction

  // Magnitude of the n-bit operand in the low bits of v; -2^(n-1) maps to 2^(n-1).
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] v,
                                             input int unsigned n,
                                             input logic is_signed);
    logic [MAX_W-1:0] mask;
    logic             sign_bit;
    mask     = (n >= MAX_W) ? '1 : ((MAX_W'(1) << n) - MAX_W'(1));
    sign_bit = |(v & (MAX_W'(1) << (n - 1)));
    if (is_signed && sign_bit) return (~v + MAX_W'(1)) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// rtl/mul_pipe_stage.sv - one accumulation stage: adds its share of partial-product rows
module mul_pipe_stage
  import mul_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned ROW_LO = 0,
  parameter int unsigned ROWS   = 8,
  parameter bit          LAST   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic             i_neg,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic [2*N-1:0]   i_acc,
  output logic             o_valid,
  output logic             o_neg,
  output logic [TAG_W-1:0] o_tag,
  output logic [N-1:0]     o_a,
  output logic [N-1:0]     o_b,
  output logic [2*N-1:0]   o_acc
);

  logic             r_valid;
  logic             r_neg;
  logic [TAG_W-1:0] r_tag;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   w_sum;
  logic [2*N-1:0]   w_next;

  // The final stage stores the signed product instead of the raw magnitude sum.
  always_comb begin
    w_sum = i_acc;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (i_b[ROW_LO + r]) w_sum = w_sum + ({{N{1'b0}}, i_a} << (ROW_LO + r));
    end
    w_next = (LAST && i_neg) ? (~w_sum + (2*N)'(1)) : w_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
      r_tag   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_neg <= i_neg;
        r_tag <= i_tag;
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= w_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_neg   = r_neg;
  assign o_tag   = r_tag;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_acc   = r_acc;

endmodule

// File: rtl/mul_pipe_stream.sv
// rtl/mul_pipe_stream.sv - pipelined N x N signed/unsigned multiplier with valid/ready streams
module mul_pipe_stream
  import mul_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned ROWS_PER_STAGE = rows_per_stage(N, STAGES);

  if (STAGES == 0 || STAGES > N || (N % STAGES) != 0 || N > MAX_W) begin : g_bad_cfg
    $error("mul_pipe_stream: N must be divisible by STAGES, with 1 <= STAGES <= N <= MAX_W");
  end

  // Index 0 is the conditioned input beat; index k+1 is the output of stage k.
  logic             w_v   [STAGES+1];
  logic             w_neg [STAGES+1];
  logic [TAG_W-1:0] w_tag [STAGES+1];
  logic [N-1:0]     w_a   [STAGES+1];
  logic [N-1:0]     w_b   [STAGES+1];
  logic [2*N-1:0]   w_acc [STAGES+1];
  logic [STAGES-1:0] w_adv;

  assign w_v[0]   = in_valid;
  assign w_neg[0] = in_signed & (in_a[N-1] ^ in_b[N-1]);
  assign w_tag[0] = in_tag;
  assign w_a[0]   = N'(abs_n(MAX_W'(in_a), N, in_signed));
  assign w_b[0]   = N'(abs_n(MAX_W'(in_b), N, in_signed));
  assign w_acc[0] = '0;

  // A stage may load when it is empty or its occupant moves on; bubbles collapse.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_v[STAGES] | out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      w_adv[i] = !w_v[i+1] | w_adv[i+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mul_pipe_stage #(
      .N      (N),
      .TAG_W  (TAG_W),
      .ROW_LO (k * ROWS_PER_STAGE),
      .ROWS   (ROWS_PER_STAGE),
      .LAST   (k == STAGES - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv[k]),
      .i_valid (w_v[k]),
      .i_neg   (w_neg[k]),
      .i_tag   (w_tag[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .i_acc   (w_acc[k]),
      .o_valid (w_v[k+1]),
      .o_neg   (w_neg[k+1]),
      .o_tag   (w_tag[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1]),
      .o_acc   (w_acc[k+1])
    );
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[STAGES];
  assign out_p     = w_acc[STAGES];
  assign out_tag   = w_tag[STAGES];

endmodule

// File: tb/tb_mul_pipe_stream.sv
// tb/tb_mul_pipe_stream.sv - directed and scoreboarded random checks for mul_pipe_stream
module tb_mul_pipe_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_p;

  mul_pipe_stream #(.N(8), .STAGES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
  );

  logic        sel, v32, s32, rdy32;
  logic [31:0] a32, b32;
  logic [3:0]  t32;
  logic        ir_1, ov_1, ir_8, ov_8;
  logic [63:0] p_1, p_8;
  logic [3:0]  ot_1, ot_8;

  mul_pipe_stream #(.N(32), .STAGES(1), .TAG_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32 & !sel), .in_ready(ir_1),
    .in_a(a32), .in_b(b32), .in_signed(s32), .in_tag(t32),
    .out_valid(ov_1), .out_ready(rdy32 & !sel), .out_p(p_1), .out_tag(ot_1)
  );

  mul_pipe_stream #(.N(32), .STAGES(8), .TAG_W(4)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32 & sel), .in_ready(ir_8),
    .in_a(a32), .in_b(b32), .in_signed(s32), .in_tag(t32),
    .out_valid(ov_8), .out_ready(rdy32 & sel), .out_p(p_8), .out_tag(ot_8)
  );

  logic        w_ir, w_ov;
  logic [63:0] w_p;
  logic [3:0]  w_ot;
  assign w_ir = sel ? ir_8 : ir_1;
  assign w_ov = sel ? ov_8 : ov_1;
  assign w_p  = sel ? p_8  : p_1;
  assign w_ot = sel ? ot_8 : ot_1;

  logic [7:0]  sv_a [5] = '{8'h80, 8'hFF, 8'h80, 8'h00, 8'h80};
  logic [7:0]  sv_b [5] = '{8'h80, 8'h01, 8'h7F, 8'hFB, 8'hFF};
  logic        sv_s [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] sv_p [5] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0000, 16'h7F80};

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [3:0] t, output bit ok);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [15:0] p, output logic [3:0] t, output int lat);
    lat = 0; p = '0; t = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) begin p = out_p; t = out_tag; lat = i; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_tag = '0;
    sel = 1'b0; v32 = 1'b0; rdy32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; t32 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_p !== 16'h0) begin errors++; $display("FAIL reset_out_p: got %h want 0000", out_p); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bit ok; logic [15:0] p; logic [3:0] t; int lat;
    out_ready = 1'b1;
    send_beat(8'hFF, 8'hFF, 1'b0, 4'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL latency_accept: got no accept want accept"); end
    wait_result(p, t, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL latency_cycles: got %0d want 4", lat); end
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL latency_product: got %h want fe01", p); end
    checks++; if (t !== 4'd3) begin errors++; $display("FAIL latency_tag: got %0d want 3", t); end
  endtask

  task automatic test_signed();
    bit ok; logic [15:0] p; logic [3:0] t; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat(sv_a[i], sv_b[i], sv_s[i], 4'(i), ok);
      wait_result(p, t, lat);
      checks++;
      if (!ok || lat == 0 || p !== sv_p[i] || t !== 4'(i)) begin
        errors++;
        $display("FAIL signed_vec%0d: got p=%h tag=%0d lat=%0d want p=%h tag=%0d", i, p, t, lat, sv_p[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, rcv; logic [15:0] e;
    out_ready = 1'b1; first = -1; rcv = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        in_valid = 1'b1; in_a = 8'(c + 1); in_b = 8'(c + 2); in_signed = 1'b0; in_tag = 4'(c);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c < 20) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (out_valid) begin
        if (first < 0) first = c;
        e = 16'((rcv + 1) * (rcv + 2));
        checks++;
        if (out_p !== e || out_tag !== 4'(rcv) || c != first + rcv) begin
          errors++;
          $display("FAIL b2b_result%0d: got p=%h tag=%0d cycle=%0d want p=%h tag=%0d cycle=%0d",
                   rcv, out_p, out_tag, c, e, 4'(rcv), first + rcv);
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    checks++; if (rcv != 20) begin errors++; $display("FAIL b2b_count: got %0d want 20", rcv); end
    checks++; if (first != 4) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 4", first); end
  endtask

  task automatic test_stall();
    int sent, rcv; logic [15:0] e;
    sent = 0; rcv = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 10);
      if (sent < 6) begin
        in_valid = 1'b1; in_a = 8'(16 + sent); in_b = 8'(3 + sent); in_signed = 1'b0; in_tag = 4'(8 + sent);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c < 10) begin
        checks++;
        if (in_ready !== (sent < 4)) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want %b", c, in_ready, sent < 4); end
      end
      if (c >= 4 && c < 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== 16'(16 * 3) || out_tag !== 4'd8) begin
          errors++;
          $display("FAIL stall_hold c%0d: got v=%b p=%h tag=%0d want v=1 p=%h tag=8", c, out_valid, out_p, out_tag, 16'(16 * 3));
        end
      end
      if (out_valid && out_ready) begin
        e = 16'((16 + rcv) * (3 + rcv));
        checks++;
        if (out_p !== e || out_tag !== 4'(8 + rcv)) begin
          errors++;
          $display("FAIL stall_result%0d: got p=%h tag=%0d want p=%h tag=%0d", rcv, out_p, out_tag, e, 4'(8 + rcv));
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    checks++; if (rcv != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", rcv); end
  endtask

  task automatic test_reset_flush();
    int rcv, sent; logic [15:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = 8'(5 + c); in_b = 8'd7; in_signed = 1'b0; in_tag = 4'(5 + c);
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    checks++; if (out_p !== 16'h0) begin errors++; $display("FAIL flush_out_p: got %h want 0000", out_p); end
    @(posedge clk); #1;
    sent = 0; rcv = 0;
    for (int c = 0; c < 20; c++) begin
      if (sent < 2) begin
        in_valid = 1'b1; in_a = 8'(9 + sent); in_b = 8'd11; in_signed = 1'b0; in_tag = 4'(10 + sent);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        e = 16'((9 + rcv) * 11);
        checks++;
        if (rcv >= 2 || out_p !== e || out_tag !== 4'(10 + rcv)) begin
          errors++;
          $display("FAIL flush_result%0d: got p=%h tag=%0d want p=%h tag=%0d", rcv, out_p, out_tag, e, 4'(10 + rcv));
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    checks++; if (rcv != 2) begin errors++; $display("FAIL flush_count: got %0d want 2", rcv); end
  endtask

  task automatic test_random(input logic which);
    logic [67:0] q[$];
    logic [67:0] e;
    int sent, rcv;
    bit took;
    sel = which; sent = 0; rcv = 0; v32 = 1'b0; rdy32 = 1'b0;
    for (int c = 0; c < 15000 && rcv < 2000; c++) begin
      if (!v32 && sent < 2000 && $urandom_range(0, 3) != 0) begin
        a32 = pick(); b32 = pick(); s32 = 1'($urandom_range(0, 1)); t32 = 4'($urandom_range(0, 15));
        v32 = 1'b1;
      end
      rdy32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (w_ov && rdy32) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_s%0d_unexpected: got p=%h tag=%0d want no result", which ? 8 : 1, w_p, w_ot);
        end else begin
          e = q.pop_front();
          if ({w_p, w_ot} !== e) begin
            errors++;
            $display("FAIL random_s%0d_beat%0d: got p=%h tag=%0d want p=%h tag=%0d",
                     which ? 8 : 1, rcv, w_p, w_ot, e[67:4], e[3:0]);
          end
        end
        rcv++;
      end
      took = v32 && w_ir;
      if (took) begin
        q.push_back({ref_mul(a32, b32, s32), t32});
        sent++;
      end
      @(posedge clk); #1;
      if (took) v32 = 1'b0;
    end
    checks++;
    if (rcv != 2000 || q.size() != 0) begin
      errors++;
      $display("FAIL random_s%0d_count: got %0d results (%0d pending) want 2000", which ? 8 : 1, rcv, q.size());
    end
    v32 = 1'b0; rdy32 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random(1'b0);
    test_random(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
